// File: rtl/start_srl_fifo_pkg.sv
// Shared constants and helpers for the start-token shift-register FIFO.
// Holds the flag reset values and the occupancy-counter width function.
package start_srl_fifo_pkg;

  localparam logic FULL_N_RST  = 1'b1;
  localparam logic EMPTY_N_RST = 1'b0;

  // Bits needed to count 0..depth inclusive.
  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/start_srl_fifo_store.sv
// Addressable shift-register array: a write shifts every entry up by one and
// loads entry 0; the read port is a plain combinational mux.
module start_srl_fifo_store #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 24
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // NOTE: storage has no reset on purpose; the occupancy count alone decides
  // which entries are meaningful, and leaving it out keeps this an SRL array.
  // NOTE: sequential state uses non-blocking assignments so every entry
  // samples its neighbour's old value, giving a true one-step shift.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        mem_q[i] <= mem_q[i-1];
      end
      mem_q[0] <= din;
    end
  end

  assign dout = mem_q[addr];

endmodule

// File: rtl/start_srl_fifo.sv
// Start-token FIFO between a producer and the systolic-array drain process:
// handshake flags, occupancy counter and read-address generation over an SRL store.
module start_srl_fifo
  import start_srl_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 24
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_write_ce,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_full_n,
  input  logic                  if_read_ce,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic                  if_empty_n,
  output logic [ADDR_WIDTH:0]   if_num_data_valid
);

  localparam int               CNT_W   = occ_width(DEPTH);
  localparam int               OUT_W   = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [CNT_W-1:0]      count_q, count_d;
  logic                  full_n_q, full_n_d;
  logic                  empty_n_q, empty_n_d;
  logic                  push, pop;
  logic [ADDR_WIDTH-1:0] rd_addr;

  assign push = if_write_ce & if_write & full_n_q;
  assign pop  = if_read_ce & if_read & empty_n_q;

  // Newest word sits at entry 0, so the oldest is at count-1.
  assign rd_addr = (count_q == '0) ? '0 : ADDR_WIDTH'(count_q - 1'b1);

  // NOTE: every next-state signal takes its hold value first, so no path
  // through this block leaves one unassigned and no latch is inferred.
  always_comb begin
    count_d   = count_q;
    full_n_d  = full_n_q;
    empty_n_d = empty_n_q;
    if (push && !pop) begin
      count_d   = count_q + 1'b1;
      empty_n_d = 1'b1;
      full_n_d  = (count_q + 1'b1) != DEPTH_C;
    end else if (pop && !push) begin
      count_d   = count_q - 1'b1;
      full_n_d  = 1'b1;
      empty_n_d = (count_q - 1'b1) != '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q   <= '0;
      full_n_q  <= FULL_N_RST;
      empty_n_q <= EMPTY_N_RST;
    end else begin
      count_q   <= count_d;
      full_n_q  <= full_n_d;
      empty_n_q <= empty_n_d;
    end
  end

  start_srl_fifo_store #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_store (
    .clk  (clk),
    .we   (push),
    .addr (rd_addr),
    .din  (if_din),
    .dout (if_dout)
  );

  assign if_full_n         = full_n_q;
  assign if_empty_n        = empty_n_q;
  assign if_num_data_valid = OUT_W'(count_q);

  a_count_bound : assert property (@(posedge clk) disable iff (reset)
    count_q <= DEPTH_C);
  a_flags_track_count : assert property (@(posedge clk) disable iff (reset)
    (full_n_q == (count_q != DEPTH_C)) && (empty_n_q == (count_q != '0)));

endmodule

// File: tb/tb_start_srl_fifo.sv
// Scoreboard bench for start_srl_fifo: a queue model tracks contents, occupancy
// and flags; every cycle the DUT outputs are compared against it.
module tb_start_srl_fifo;

  localparam int DW    = 1;
  localparam int AW    = 5;
  localparam int DEPTH = 24;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_write_ce, if_write, if_read_ce, if_read;
  logic [DW-1:0] if_din;
  logic [DW-1:0] if_dout;
  logic          if_full_n, if_empty_n;
  logic [AW:0]   if_num_data_valid;

  logic [DW-1:0] sb_q [$];
  int            n_vec = 0;
  int            n_err = 0;

  always #5 clk = ~clk;

  start_srl_fifo #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .DEPTH      (DEPTH)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .if_write_ce       (if_write_ce),
    .if_write          (if_write),
    .if_din            (if_din),
    .if_full_n         (if_full_n),
    .if_read_ce        (if_read_ce),
    .if_read           (if_read),
    .if_dout           (if_dout),
    .if_empty_n        (if_empty_n),
    .if_num_data_valid (if_num_data_valid)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, compare outputs with the model, clock, update model.
  task automatic step(input logic wce, input logic w, input logic [DW-1:0] d,
                      input logic rce, input logic r, input logic rst);
    bit push, pop;
    reset       = rst;
    if_write_ce = wce;
    if_write    = w;
    if_din      = d;
    if_read_ce  = rce;
    if_read     = r;
    #1;
    check("count", 32'(if_num_data_valid), 32'(sb_q.size()));
    check("full_n", 32'(if_full_n), 32'(sb_q.size() != DEPTH));
    check("empty_n", 32'(if_empty_n), 32'(sb_q.size() != 0));
    if (sb_q.size() != 0) check("dout", 32'(if_dout), 32'(sb_q[0]));
    push = wce && w && (sb_q.size() < DEPTH);
    pop  = rce && r && (sb_q.size() > 0);
    @(posedge clk);
    #1;
    if (rst) begin
      sb_q.delete();
    end else begin
      if (pop) void'(sb_q.pop_front());
      if (push) sb_q.push_back(d);
    end
  endtask

  task automatic idle();
    step(1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic wr(input logic [DW-1:0] d);
    step(1'b1, 1'b1, d, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic rd();
    step(1'b1, 1'b0, '0, 1'b1, 1'b1, 1'b0);
  endtask

  initial begin
    int phase_wr_pct;

    // Reset, then idle; a read on empty must be ignored.
    reset = 1'b1;
    if_write_ce = 1'b0; if_write = 1'b0; if_din = '0;
    if_read_ce  = 1'b0; if_read  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    sb_q.delete();
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    repeat (5) idle();
    rd();
    check("empty_read_count", 32'(if_num_data_valid), 32'd0);
    check("empty_read_empty_n", 32'(if_empty_n), 32'd0);

    // Fill with alternating 1,0; the 25th push must be dropped.
    for (int i = 0; i < DEPTH + 1; i++) wr(DW'((i + 1) % 2));
    check("full_count", 32'(if_num_data_valid), 32'(DEPTH));
    check("full_full_n", 32'(if_full_n), 32'd0);
    for (int i = 0; i < DEPTH; i++) rd();
    check("drained_empty_n", 32'(if_empty_n), 32'd0);
    check("drained_full_n", 32'(if_full_n), 32'd1);
    rd();

    // Fill to 3 then simultaneous push+pop: occupancy and flags hold.
    wr(1'b0); wr(1'b1); wr(1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    check("pp_count", 32'(if_num_data_valid), 32'd3);
    repeat (3) rd();

    // Write CE low freezes the write side, pops still go through.
    repeat (4) step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check("wce_off_count", 32'(if_num_data_valid), 32'd0);
    wr(1'b1);
    check("fwft_dout", 32'(if_dout), 32'd1);
    wr(1'b0);
    check("wce_on_count", 32'(if_num_data_valid), 32'd2);
    repeat (2) step(1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    check("rce_off_count", 32'(if_num_data_valid), 32'd2);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    check("wce_off_pop_count", 32'(if_num_data_valid), 32'd1);
    rd();

    // Fill to 10, then reset together with push+pop.
    for (int i = 0; i < 10; i++) wr(DW'(i % 2));
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    check("rst_count", 32'(if_num_data_valid), 32'd0);
    check("rst_empty_n", 32'(if_empty_n), 32'd0);
    check("rst_full_n", 32'(if_full_n), 32'd1);

    // Random traffic with write-bias phases so both boundaries get exercised.
    phase_wr_pct = 50;
    for (int i = 0; i < 10000; i++) begin
      if (i % 400 == 0) phase_wr_pct = int'($urandom_range(15, 85));
      step(logic'($urandom_range(0, 9) != 0),
           logic'($urandom_range(0, 99) < phase_wr_pct),
           DW'($urandom),
           logic'($urandom_range(0, 9) != 0),
           logic'($urandom_range(0, 99) >= phase_wr_pct),
           logic'($urandom_range(0, 1999) == 0));
    end
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
